// File: rtl/masked_sbox_sequencer.sv
// masked_sbox_sequencer
//   Feeds a 16-nibble masked Skinny-64 state through one shared masked S-box, one nibble at a time.
//   Each nibble draws a fresh randomness word from the PRNG. The S-box inputs and the word are then
//   held for SBOX_LAT cycles, and the S-box result is written back into out_shares.
//   Shares are only ever moved lane-to-lane. They are never combined with each other.
// Ports
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   start        pulse, accepted only in IDLE; latches in_shares
//   in_shares    share j at [j*4*NIBBLES +: 4*NIBBLES], nibble i at offset 4*i within its share
//   busy, done   busy outside IDLE; done is a one-cycle pulse when out_shares is complete
//   out_shares   result, same layout as in_shares, written one nibble per STORE
//   fresh_req    PRNG request; fresh_valid/fresh_data complete the handshake
//   sbox_in      {share N-1 nibble, ..., share 0 nibble} to the S-box (registered)
//   sbox_fresh   registered randomness word for the S-box
//   sbox_out     S-box result, same share order as sbox_in
module masked_sbox_sequencer #(
  parameter int unsigned SECURITY_ORDER = 3,
  parameter int unsigned NIBBLES        = 16,
  parameter int unsigned SBOX_LAT       = 13,
  parameter int unsigned FRESH_W        = 102
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [4*NIBBLES*(SECURITY_ORDER+1)-1:0]   in_shares,
  output logic                                      busy,
  output logic                                      done,
  output logic [4*NIBBLES*(SECURITY_ORDER+1)-1:0]   out_shares,
  output logic                                      fresh_req,
  input  logic                                      fresh_valid,
  input  logic [FRESH_W-1:0]                        fresh_data,
  output logic [4*(SECURITY_ORDER+1)-1:0]           sbox_in,
  output logic [FRESH_W-1:0]                        sbox_fresh,
  input  logic [4*(SECURITY_ORDER+1)-1:0]           sbox_out
);

  localparam int unsigned Shares = SECURITY_ORDER + 1;
  localparam int unsigned ShareW = 4 * NIBBLES;
  localparam int unsigned StateW = ShareW * Shares;
  localparam int unsigned CntW   = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam int unsigned IdxW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(SBOX_LAT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

  typedef enum logic [2:0] {StIdle, StRnd, StEval, StStore, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [StateW-1:0]      shares_q, shares_d;
  logic [StateW-1:0]      out_q, out_d;
  logic [4*Shares-1:0]    sbox_in_q, sbox_in_d;
  logic [FRESH_W-1:0]     sbox_fresh_q, sbox_fresh_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      shares_q     <= '0;
      out_q        <= '0;
      sbox_in_q    <= '0;
      sbox_fresh_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shares_q     <= shares_d;
      out_q        <= out_d;
      sbox_in_q    <= sbox_in_d;
      sbox_fresh_q <= sbox_fresh_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shares_d     = shares_q;
    out_d        = out_q;
    sbox_in_d    = sbox_in_q;
    sbox_fresh_d = sbox_fresh_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shares_d = in_shares;
          idx_d    = '0;
          state_d  = StRnd;
        end
      end
      StRnd: begin
        // S-box inputs stay zero until the randomness for this nibble has arrived.
        if (fresh_valid) begin
          sbox_fresh_d = fresh_data;
          for (int j = 0; j < Shares; j++) begin
            sbox_in_d[4*j +: 4] = shares_q[j*ShareW + 4*32'(idx_q) +: 4];
          end
          cnt_d   = '0;
          state_d = StEval;
        end
      end
      StEval: begin
        if (cnt_q == CntLast) begin
          state_d = StStore;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStore: begin
        for (int j = 0; j < Shares; j++) begin
          out_d[j*ShareW + 4*32'(idx_q) +: 4] = sbox_out[4*j +: 4];
        end
        sbox_in_d    = '0;
        sbox_fresh_d = '0;
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StRnd;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    fresh_req  = (state_q == StRnd);
    out_shares = out_q;
    sbox_in    = sbox_in_q;
    sbox_fresh = sbox_fresh_q;
  end

endmodule
